// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router output switch:
//   - default beat / destination widths
//   - beat flag record {hdr, pld, sof, eof}; the full beat record adds data
//   - arbiter state encoding (IDLE / BUSY)
//   - rr_next(): circular priority pick used by the round-robin arbiter
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int DEST_WIDTH_DEF = 8;

    // Widest request vector rr_next() can scan.
    localparam int MAX_PORTS = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Control part of a beat. The data field is added where the width is known.
    typedef struct packed {
        logic hdr;
        logic pld;
        logic sof;
        logic eof;
    } beat_flags_t;

    // Returns the first set bit of req, searching circularly from last+1 over
    // num_ports entries. Returns last when nothing is set.
    function automatic int unsigned rr_next(
        input logic [MAX_PORTS-1:0] req,
        input int unsigned          last,
        input int unsigned          num_ports
    );
        int unsigned pick;
        int unsigned idx;
        pick = last;
        // Walk from the farthest candidate to the nearest so the nearest
        // requester after 'last' is the one left in 'pick'.
        for (int unsigned k = MAX_PORTS; k >= 1; k--) begin
            if (k <= num_ports) begin
                idx = (last + k) % num_ports;
                if (req[4'(idx)]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/router_mux_rr_if.sv
// -----------------------------------------------------------------------------
// router_mux_rr_if
// Bus bundle of one router output switch.
//   Input side (from all router input ports, broadcast):
//     D, DEST, D_HDR_VALID, D_PLD_VALID, D_SOF, D_EOF  -> switch
//     D_BP                                             <- switch (per-port stall)
//   Output side (towards the output port):
//     Q, Q_HDR_VALID, Q_PLD_VALID, Q_SOF, Q_EOF        <- switch
//     Q_BP                                             -> switch (downstream stall)
//   Status: GRANT (one-hot owner), FRAME_CNT (completed frames)
// Modports: slave = the switch, master = the environment driving it.
// -----------------------------------------------------------------------------
interface router_mux_rr_if
    import router_pkg::*;
#(
    parameter int NumPorts  = 4,
    parameter int DataWidth = DATA_WIDTH_DEF,
    parameter int DestWidth = DEST_WIDTH_DEF
);

    logic [NumPorts*DataWidth-1:0] D;
    logic [NumPorts*DestWidth-1:0] DEST;
    logic [NumPorts-1:0]           D_HDR_VALID;
    logic [NumPorts-1:0]           D_PLD_VALID;
    logic [NumPorts-1:0]           D_SOF;
    logic [NumPorts-1:0]           D_EOF;
    logic [NumPorts-1:0]           D_BP;

    logic [DataWidth-1:0]          Q;
    logic                          Q_HDR_VALID;
    logic                          Q_PLD_VALID;
    logic                          Q_SOF;
    logic                          Q_EOF;
    logic                          Q_BP;

    logic [NumPorts-1:0]           GRANT;
    logic [15:0]                   FRAME_CNT;

    modport slave (
        input  D, DEST, D_HDR_VALID, D_PLD_VALID, D_SOF, D_EOF, Q_BP,
        output D_BP, Q, Q_HDR_VALID, Q_PLD_VALID, Q_SOF, Q_EOF, GRANT, FRAME_CNT
    );

    modport master (
        output D, DEST, D_HDR_VALID, D_PLD_VALID, D_SOF, D_EOF, Q_BP,
        input  D_BP, Q, Q_HDR_VALID, Q_PLD_VALID, Q_SOF, Q_EOF, GRANT, FRAME_CNT
    );

endinterface

// File: rtl/router_beat_fifo.sv
// -----------------------------------------------------------------------------
// router_beat_fifo
// Synchronous FIFO for switch beats. Depth must be a power of two (>= 2) so
// the pointers wrap naturally.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   push       write request (refused while full)
//   wr_data    beat to write
//   pop        read request (ignored while empty)
//   rd_data    head entry; holds the last presented head while empty, 0 after reset
//   empty      no entries stored
//   count      number of stored entries (0..Depth)
// -----------------------------------------------------------------------------
module router_beat_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  logic [Width-1:0]       wr_data,
    input  logic                   pop,
    output logic [Width-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);

    localparam int          AW      = $clog2(Depth);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [Width-1:0] hold_q;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign wr_en   = push & ~full;
    assign rd_en   = pop & ~empty;
    assign rd_data = empty ? hold_q : mem[rd_ptr_q];

    // NOTE: the storage array has no reset; count_q gates every read, so stale
    // entries are never visible and the array can map onto plain RAM/flops.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // NOTE: sequential state is always updated with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: ;
            endcase
            // Remember the head so the output keeps its value once drained.
            if (!empty) begin
                hold_q <= rd_data;
            end
        end
    end

endmodule

// File: rtl/router_mux_rr.sv
// -----------------------------------------------------------------------------
// router_mux_rr
// N-to-1 output switch of the router crossbar (one instance per output port).
// Picks whole frames addressed to PortNo with round-robin arbitration, holds
// the winner until its EOF, and buffers beats in an output FIFO so the
// downstream stall never loses data.
// Ports:
//   CLK   clock
//   RST   synchronous active-high reset (drops any partial frame)
//   bus   router_mux_rr_if.slave:
//         D/DEST/D_*_VALID/D_SOF/D_EOF in, D_BP out (combinational, per port)
//         Q/Q_*_VALID/Q_SOF/Q_EOF out (FIFO head), Q_BP in
//         GRANT (one-hot owner, 0 when idle), FRAME_CNT (frames completed)
// -----------------------------------------------------------------------------
module router_mux_rr
    import router_pkg::*;
#(
    parameter int NumPorts  = 4,
    parameter int DataWidth = DATA_WIDTH_DEF,
    parameter int DestWidth = DEST_WIDTH_DEF,
    parameter int PortNo    = 1,
    parameter int FifoDepth = 4
) (
    input  logic           CLK,
    input  logic           RST,
    router_mux_rr_if.slave bus
);

    localparam int IW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int CW = $clog2(FifoDepth) + 1;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        beat_flags_t          flags;
    } beat_t;

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        grant_idx_q, grant_idx_d;
    logic [15:0]          frame_cnt_q;

    logic [NumPorts-1:0]  vld;
    logic [NumPorts-1:0]  req;
    logic [NumPorts-1:0]  d_bp;
    logic [NumPorts-1:0]  grant;
    logic [DataWidth-1:0] d_arr [NumPorts];
    logic [IW-1:0]        win;
    logic [IW-1:0]        sel;
    logic                 any_req;
    logic                 sel_en;
    logic                 push;
    logic                 pop;
    logic                 frame_done;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    beat_t                wr_beat;
    beat_t                head_beat;

    // ------------------------------------------------------------------ requests
    assign vld = bus.D_HDR_VALID | bus.D_PLD_VALID;

    for (genvar i = 0; i < NumPorts; i++) begin : g_port
        assign d_arr[i] = bus.D[i*DataWidth +: DataWidth];
        assign req[i]   = vld[i] & bus.D_SOF[i]
                        & (bus.DEST[i*DestWidth +: DestWidth] == DestWidth'(PortNo));
    end

    assign any_req   = |req;
    assign win       = IW'(rr_next(MAX_PORTS'(req), 32'(last_q), NumPorts));
    assign fifo_full = (fifo_count == CW'(FifoDepth));

    // ------------------------------------------------------- arbiter / frame FSM
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_idx_d = grant_idx_q;
        // Other requesters wait; traffic for other outputs is never stalled here.
        d_bp        = req;
        sel         = grant_idx_q;
        sel_en      = 1'b0;
        frame_done  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                sel    = win;
                sel_en = any_req;
                if (any_req) begin
                    d_bp[win] = fifo_full;
                end
            end
            ST_BUSY: begin
                sel             = grant_idx_q;
                sel_en          = 1'b1;
                d_bp[grant_idx_q] = fifo_full;
            end
            default: ;
        endcase

        // Idle gaps on the owner (no valid) are simply not written.
        push = sel_en & vld[sel] & ~fifo_full;

        if (push) begin
            if (state_q == ST_IDLE) begin
                last_d = win;
                if (bus.D_EOF[sel]) begin
                    frame_done = 1'b1;          // single-beat frame, stay idle
                end else begin
                    state_d     = ST_BUSY;
                    grant_idx_d = win;
                end
            end else if (bus.D_EOF[sel]) begin
                state_d    = ST_IDLE;           // next SOF can win next cycle
                frame_done = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (state_q == ST_BUSY) begin
            grant[grant_idx_q] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            last_q      <= IW'(NumPorts - 1);
            grant_idx_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_idx_q <= grant_idx_d;
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------- output FIFO
    always_comb begin
        wr_beat.data      = d_arr[sel];
        wr_beat.flags.hdr = bus.D_HDR_VALID[sel];
        wr_beat.flags.pld = bus.D_PLD_VALID[sel];
        wr_beat.flags.sof = bus.D_SOF[sel];
        wr_beat.flags.eof = bus.D_EOF[sel];
    end

    assign pop = ~fifo_empty & ~bus.Q_BP;

    router_beat_fifo #(
        .Width (DataWidth + $bits(beat_flags_t)),
        .Depth (FifoDepth)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push    (push),
        .wr_data (wr_beat),
        .pop     (pop),
        .rd_data (head_beat),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // ----------------------------------------------------------------- outputs
    assign bus.D_BP        = d_bp;
    assign bus.Q           = head_beat.data;      // keeps last value when empty
    assign bus.Q_HDR_VALID = ~fifo_empty & head_beat.flags.hdr;
    assign bus.Q_PLD_VALID = ~fifo_empty & head_beat.flags.pld;
    assign bus.Q_SOF       = ~fifo_empty & head_beat.flags.sof;
    assign bus.Q_EOF       = ~fifo_empty & head_beat.flags.eof;
    assign bus.GRANT       = grant;
    assign bus.FRAME_CNT   = frame_cnt_q;

    // A SOF from the owner mid-frame is carried as data; it is only flagged here.
    a_no_sof_while_busy : assert property (
        @(posedge CLK) disable iff (RST)
        !((state_q == ST_BUSY) && push && bus.D_SOF[sel])
    );

endmodule

// File: tb/tb_router_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_router_mux_rr
// Directed bench for router_mux_rr (NumPorts=4, DataWidth=64, DestWidth=8,
// PortNo=1, FifoDepth=4). Inputs change at the falling edge; registered and
// combinational outputs are sampled at the falling edge or just after a drive.
// -----------------------------------------------------------------------------
module tb_router_mux_rr;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int SW = 8;
    localparam int PN = 1;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    router_mux_rr_if #(.NumPorts(NP), .DataWidth(DW), .DestWidth(SW)) bus ();

    router_mux_rr #(
        .NumPorts  (NP),
        .DataWidth (DW),
        .DestWidth (SW),
        .PortNo    (PN),
        .FifoDepth (FD)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {hdr, pld, sof, eof} of the output head
    function automatic logic [3:0] qflags();
        return {bus.Q_HDR_VALID, bus.Q_PLD_VALID, bus.Q_SOF, bus.Q_EOF};
    endfunction

    task automatic clear_in();
        bus.D           = '0;
        bus.DEST        = '0;
        bus.D_HDR_VALID = '0;
        bus.D_PLD_VALID = '0;
        bus.D_SOF       = '0;
        bus.D_EOF       = '0;
    endtask

    task automatic drive(input int p, input logic [63:0] data, input logic [7:0] dest,
                         input logic hdr, input logic pld, input logic sof, input logic eof);
        bus.D[p*DW +: DW]    = data;
        bus.DEST[p*SW +: SW] = dest;
        bus.D_HDR_VALID[p]   = hdr;
        bus.D_PLD_VALID[p]   = pld;
        bus.D_SOF[p]         = sof;
        bus.D_EOF[p]         = eof;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        bus.Q_BP = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] out_data [8];
        logic [3:0]  out_flag [8];
        int          n_out;
        int          k;
        int          n_seq [NP];
        int          w;
        int          guard;
        logic        acc;

        // ---------------------------------------------------------------- reset
        do_reset();
        check("rst GRANT", 64'(bus.GRANT), 64'h0);
        check("rst flags", 64'(qflags()), 64'h0);
        check("rst Q", bus.Q, 64'h0);
        check("rst FRAME_CNT", 64'(bus.FRAME_CNT), 64'h0);
        check("rst D_BP", 64'(bus.D_BP), 64'h0);

        // -------------------------------- two 3-beat frames, ports 0 and 2 tie
        drive(0, 64'hA0, 8'd1, 1, 0, 1, 0);
        drive(2, 64'hC0, 8'd1, 1, 0, 1, 0);
        #1 check("t1 D_BP tie", 64'(bus.D_BP), 64'h4);
        cyc();
        check("t1 GRANT p0", 64'(bus.GRANT), 64'h1);
        check("t1 Q A0", bus.Q, 64'hA0);
        check("t1 flags A0", 64'(qflags()), 64'hA);
        drive(0, 64'hA1, 8'd0, 0, 1, 0, 0);
        #1 check("t1 D_BP b2", 64'(bus.D_BP), 64'h4);
        cyc();
        check("t1 Q A1", bus.Q, 64'hA1);
        check("t1 flags A1", 64'(qflags()), 64'h4);
        drive(0, 64'hA2, 8'd0, 0, 1, 0, 1);
        #1 check("t1 D_BP b3", 64'(bus.D_BP), 64'h4);
        cyc();
        check("t1 Q A2", bus.Q, 64'hA2);
        check("t1 flags A2", 64'(qflags()), 64'h5);
        check("t1 GRANT idle", 64'(bus.GRANT), 64'h0);
        check("t1 FRAME_CNT 1", 64'(bus.FRAME_CNT), 64'h1);
        drive(0, 64'h0, 8'd0, 0, 0, 0, 0);
        #1 check("t1 D_BP p2 go", 64'(bus.D_BP), 64'h0);
        cyc();
        check("t1 Q C0", bus.Q, 64'hC0);
        check("t1 flags C0", 64'(qflags()), 64'hA);
        check("t1 GRANT p2", 64'(bus.GRANT), 64'h4);
        drive(2, 64'hC1, 8'd0, 0, 1, 0, 0);
        cyc();
        check("t1 Q C1", bus.Q, 64'hC1);
        drive(2, 64'hC2, 8'd0, 0, 1, 0, 1);
        cyc();
        check("t1 Q C2", bus.Q, 64'hC2);
        check("t1 flags C2", 64'(qflags()), 64'h5);
        check("t1 FRAME_CNT 2", 64'(bus.FRAME_CNT), 64'h2);
        check("t1 GRANT end", 64'(bus.GRANT), 64'h0);
        clear_in();
        cyc();
        check("t1 drained flags", 64'(qflags()), 64'h0);
        check("t1 Q held", bus.Q, 64'hC2);

        // ----------------------- all ports request 1-beat frames continuously
        do_reset();
        for (int p = 0; p < NP; p++) n_seq[p] = 0;
        for (int c = 0; c < 5; c++) begin
            w = c % NP;                          // expected order 0,1,2,3,0
            for (int p = 0; p < NP; p++) begin
                drive(p, 64'(p * 256 + n_seq[p]), 8'd1, 1, 0, 1, 1);
            end
            #1 check($sformatf("t2 D_BP c%0d", c), 64'(bus.D_BP), 64'(~(4'b1 << w) & 4'hF));
            cyc();
            check($sformatf("t2 Q c%0d", c), bus.Q, 64'(w * 256 + n_seq[w]));
            check($sformatf("t2 flags c%0d", c), 64'(qflags()), 64'hB);
            n_seq[w]++;
        end
        check("t2 FRAME_CNT 5", 64'(bus.FRAME_CNT), 64'h5);
        clear_in();
        cyc();
        check("t2 drained flags", 64'(qflags()), 64'h0);

        // ------------------------------------- frame for another output port
        drive(1, 64'h777, 8'd3, 1, 0, 1, 0);
        #1 check("t3 D_BP sof", 64'(bus.D_BP), 64'h0);
        cyc();
        check("t3 flags sof", 64'(qflags()), 64'h0);
        drive(1, 64'h778, 8'd3, 0, 1, 0, 1);
        #1 check("t3 D_BP eof", 64'(bus.D_BP), 64'h0);
        cyc();
        check("t3 flags eof", 64'(qflags()), 64'h0);
        check("t3 FRAME_CNT", 64'(bus.FRAME_CNT), 64'h5);
        check("t3 GRANT", 64'(bus.GRANT), 64'h0);
        clear_in();

        // --------------------------- 8-beat frame from port 3 against Q_BP=1
        bus.Q_BP = 1'b1;
        k = 0;
        for (int c = 0; c < 7; c++) begin
            drive(3, 64'h300 + 64'(k), 8'd1, (k == 0), (k != 0), (k == 0), (k == 7));
            #1 check($sformatf("t4 D_BP3 c%0d", c), 64'(bus.D_BP[3]), 64'(c >= 4));
            acc = ~bus.D_BP[3];
            if (c == 4) begin
                check("t4 GRANT p3", 64'(bus.GRANT), 64'h8);
                check("t4 Q head", bus.Q, 64'h300);
                check("t4 flags head", 64'(qflags()), 64'hA);
            end
            cyc();
            if (acc) k++;
        end
        bus.Q_BP = 1'b0;
        n_out = 0;
        guard = 0;
        while ((n_out < 8 || k < 8) && guard < 40) begin
            if ((bus.Q_HDR_VALID | bus.Q_PLD_VALID) && !bus.Q_BP && n_out < 8) begin
                out_data[n_out] = bus.Q;
                out_flag[n_out] = qflags();
                n_out++;
            end
            if (k < 8) begin
                drive(3, 64'h300 + 64'(k), 8'd1, (k == 0), (k != 0), (k == 0), (k == 7));
            end else begin
                clear_in();
            end
            #1 acc = (k < 8) && !bus.D_BP[3];
            cyc();
            if (acc) k++;
            guard++;
        end
        clear_in();
        check("t4 beats out", 64'(n_out), 64'd8);
        for (int j = 0; j < n_out; j++) begin
            check($sformatf("t4 data %0d", j), out_data[j], 64'h300 + 64'(j));
            check($sformatf("t4 flags %0d", j), 64'(out_flag[j]),
                  (j == 0) ? 64'hA : ((j == 7) ? 64'h5 : 64'h4));
        end
        cyc();
        check("t4 FRAME_CNT", 64'(bus.FRAME_CNT), 64'h6);
        check("t4 drained flags", 64'(qflags()), 64'h0);

        // --------------------------------------------- reset in the mid-frame
        drive(0, 64'h500, 8'd1, 1, 0, 1, 0);
        cyc();
        drive(0, 64'h501, 8'd0, 0, 1, 0, 0);
        cyc();
        drive(0, 64'h502, 8'd0, 0, 1, 0, 0);
        cyc();
        check("t5 GRANT busy", 64'(bus.GRANT), 64'h1);
        drive(0, 64'h503, 8'd0, 0, 1, 0, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        clear_in();
        check("t5 GRANT", 64'(bus.GRANT), 64'h0);
        check("t5 flags", 64'(qflags()), 64'h0);
        check("t5 FRAME_CNT", 64'(bus.FRAME_CNT), 64'h0);
        check("t5 Q", bus.Q, 64'h0);
        drive(0, 64'h555, 8'd1, 1, 0, 1, 1);
        #1 check("t5 D_BP new", 64'(bus.D_BP), 64'h0);
        cyc();
        check("t5 Q new", bus.Q, 64'h555);
        check("t5 flags new", 64'(qflags()), 64'hB);
        check("t5 FRAME_CNT new", 64'(bus.FRAME_CNT), 64'h1);
        clear_in();

        // ------------------------------------------------- frame counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        #1 check("t6 FRAME_CNT pre", 64'(bus.FRAME_CNT), 64'hFFFF);
        release dut.frame_cnt_q;
        drive(2, 64'h999, 8'd1, 1, 0, 1, 1);
        cyc();
        check("t6 FRAME_CNT wrap", 64'(bus.FRAME_CNT), 64'h0);
        check("t6 Q", bus.Q, 64'h999);
        clear_in();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
